sys_bus_fabric: RTL and testbench
=================================

// Module: sys_bus_fabric
// PURPOSE
//  Parametrised system bus for 65Org16/65xx SoC tops. Replaces hand-coded per-top decode and read mux.
//  Decodes CPU address into NSLV slave selects, registers read data back to the CPU, and inserts
//  per-slot wait states via cpu_rdy. Provides a built-in LED register and exactly one strobe per access.
// PARAMETERS
//  DW        16          data width
//  AW        32          address width
//  NSLV      4           slave slots (1..8)
//  SEL_LSB   16          lsb of decode field in cpu_ab
//  SEL_W     8           decode field width
//  SLV_BASE  {8'hff,8'hfe,8'h00,8'h00}  packed NSLV*SEL_W match values, slot0 in lsbs
//  SLV_MASK  {8'hff,8'hff,8'h80,8'h00}  packed NSLV*SEL_W; slot k hit = (field & mask)==(base & mask)
//  SLV_WAIT  {2'd0,2'd1,2'd2,2'd0}       packed NSLV*2 wait states per slot (0..3)
//  LED_SEL   8'hfd       decode value of internal LED register
//  LED_W     8           LED register width (<=DW)
// PORTS
//  clk           in   1        system clock, rising edge
//  reset         in   1        asynchronous, active-high
//  cpu_ab        in   AW       CPU address
//  cpu_do        in   DW       CPU write data
//  cpu_we        in   1        CPU write enable
//  cpu_di        out  DW       registered read data to CPU
//  cpu_rdy       out  1        CPU ready; low = hold current bus cycle
//  slv_sel       out  NSLV     one-hot decoded select (level, whole access)
//  slv_rd        out  1        read strobe, completing cycle only
//  slv_wr        out  1        write strobe, completing cycle only
//  slv_dout      in   NSLV*DW  slave read data, slot0 in lsbs
//  led           out  LED_W    LED register
//  unmapped_cnt  out  8        unmapped-access counter (see CONFIGURATION)
// BEHAVIOUR
//  Decode: LED_SEL checked first; then lowest-index hitting slot wins on overlap. No hit = unmapped.
//  FSM states: IDLE, WAIT. cnt is 2-bit.
//   IDLE: access to slot k with W=SLV_WAIT[k]>0 -> cpu_rdy=0 combinationally, cnt<=W-1, go WAIT.
//         W=0, LED, unmapped -> cpu_rdy=1, access completes this cycle, stay IDLE.
//   WAIT: cpu_rdy = (cnt==0); cnt decrements while nonzero; cnt==0 -> access completes, go IDLE.
//   Total cpu_rdy-low cycles per access = SLV_WAIT[k]. cpu_ab held by CPU while cpu_rdy=0.
//  Strobes: slv_rd=!cpu_we & completing & slot hit; slv_wr=cpu_we & completing & slot hit. One per access.
//  Read data: every rising edge cpu_di <= slv_dout[k] (selected slot), {LED zero-ext} for LED, 0 if unmapped;
//   1-cycle latency: cpu_di valid cycle after completing cycle. Writes do not update cpu_di.
//  LED: on completing write to LED_SEL, led <= cpu_do[LED_W-1:0].
//  Reset (async): state=IDLE, cnt=0, cpu_di=0, led=0, unmapped_cnt=0. cpu_rdy/slv_* then follow IDLE
//   decode. Reset during WAIT aborts access; no strobe issued.
//  Back-to-back accesses to waited slots: each re-enters WAIT from IDLE; no bubble beyond SLV_WAIT.
// CONFIGURATION
//  SYS_BUS_UNMAPPED_CNT_EN defined: unmapped_cnt increments on each completing unmapped access,
//   saturates at 8'hff, reset only by reset.
//  Undefined: unmapped_cnt tied 8'h00, no counter logic.
// STRUCTURE
//  Package sys_bus_pkg: FSM state localparams, WAIT field width (2), default base/mask/wait tables.
//  Sub-module sys_bus_decode: combinational priority decoder (cpu_ab -> slv_sel, led_hit,
//   unmapped, slot wait value). FSM, data register, LED, and counter stay in sys_bus_fabric.
// TESTING
//  1 Reset asserted mid-WAIT on slot1 -> cpu_rdy high next cycle, no slv_rd pulse, led=0, cpu_di=0.
//  2 Read 0x0000_0010, slot3, W=0, slv_dout[3]=16'h1234 -> cpu_rdy stays 1, slv_rd one cycle,
//    cpu_di=16'h1234 next cycle.
//  3 Read 0xfe00_0001, slot2, W=1 -> cpu_rdy low exactly 1 cycle, single slv_rd on completing cycle,
//    cpu_di=slv_dout[2] one cycle later.
//  4 Write 16'h00a5 to 0xfd00_0000 -> led=8'ha5 after edge, no slv_wr; read back -> cpu_di=16'h00a5.
//  5 Read 0x8000_0000 (unmapped) x3 -> cpu_di=0, no strobes, unmapped_cnt=3 with
//    SYS_BUS_UNMAPPED_CNT_EN, 0 without; 300 accesses -> saturates at 8'hff.
//  6 Back-to-back write slot1 (W=2) then read slot1 -> cpu_rdy low 2+2 cycles, exactly one slv_wr
//    then one slv_rd.

Source files
------------

// File: rtl/sys_bus_pkg.sv
// sys_bus_pkg: shared types and default tables for the sys_bus fabric.
//   state_t       FSM state encoding (IDLE / WAIT)
//   WAIT_W        width of one per-slot wait-state field
//   DEF_SLV_*     default 4-slot decode map (slot0 in lsbs)
package sys_bus_pkg;

    localparam int WAIT_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int DEF_NSLV  = 4;
    localparam int DEF_SEL_W = 8;

    localparam logic [DEF_NSLV*DEF_SEL_W-1:0] DEF_SLV_BASE = {8'hff, 8'hfe, 8'h00, 8'h00};
    localparam logic [DEF_NSLV*DEF_SEL_W-1:0] DEF_SLV_MASK = {8'hff, 8'hff, 8'h80, 8'h00};
    localparam logic [DEF_NSLV*WAIT_W-1:0]    DEF_SLV_WAIT = {2'd0, 2'd1, 2'd2, 2'd0};
    localparam logic [DEF_SEL_W-1:0]          DEF_LED_SEL  = 8'hfd;

endpackage

// File: rtl/sys_bus_decode.sv
// sys_bus_decode: combinational priority address decoder.
//   cpu_ab      in   AW     CPU address; field cpu_ab[SEL_LSB +: SEL_W] is decoded
//   slv_sel_o   out  NSLV   one-hot slot select (zero for LED or unmapped)
//   led_hit_o   out  1      address hits the internal LED register
//   unmapped_o  out  1      neither LED nor any slot hit
//   wait_o      out  WAIT_W wait states of the selected slot (0 otherwise)
// The LED decode value is checked before the slot table; among slots the
// lowest index wins when match windows overlap.
module sys_bus_decode
    import sys_bus_pkg::*;
#(
    parameter int                      AW       = 32,
    parameter int                      NSLV     = DEF_NSLV,
    parameter int                      SEL_LSB  = 16,
    parameter int                      SEL_W    = DEF_SEL_W,
    parameter logic [NSLV*SEL_W-1:0]   SLV_BASE = DEF_SLV_BASE,
    parameter logic [NSLV*SEL_W-1:0]   SLV_MASK = DEF_SLV_MASK,
    parameter logic [NSLV*WAIT_W-1:0]  SLV_WAIT = DEF_SLV_WAIT,
    parameter logic [SEL_W-1:0]        LED_SEL  = DEF_LED_SEL
) (
    input  logic [AW-1:0]     cpu_ab,
    output logic [NSLV-1:0]   slv_sel_o,
    output logic              led_hit_o,
    output logic              unmapped_o,
    output logic [WAIT_W-1:0] wait_o
);

    logic [SEL_W-1:0] field;
    logic             found;
    logic             unused_ab;

    assign field     = cpu_ab[SEL_LSB +: SEL_W];
    // Only the decode field matters; the rest of the address belongs to the slaves.
    assign unused_ab = ^cpu_ab;

    always_comb begin
        slv_sel_o = '0;
        wait_o    = '0;
        found     = 1'b0;
        led_hit_o = (field == LED_SEL);
        if (!led_hit_o) begin
            for (int k = 0; k < NSLV; k++) begin
                if (!found &&
                    ((field & SLV_MASK[k*SEL_W +: SEL_W]) ==
                     (SLV_BASE[k*SEL_W +: SEL_W] & SLV_MASK[k*SEL_W +: SEL_W]))) begin
                    found        = 1'b1;
                    slv_sel_o[k] = 1'b1;
                    wait_o       = SLV_WAIT[k*WAIT_W +: WAIT_W];
                end
            end
        end
        unmapped_o = !led_hit_o && !found;
    end

endmodule

// File: rtl/sys_bus_fabric.sv
// sys_bus_fabric: parametrised system bus for 65xx SoC tops.
//   clk, reset    clock (rising edge), asynchronous active-high reset
//   cpu_ab/do/we  CPU address, write data, write enable
//   cpu_di        registered read data (valid the cycle after completion)
//   cpu_rdy       low holds the current CPU bus cycle (wait states)
//   slv_sel       one-hot slot select, level for the whole access
//   slv_rd/wr     single strobe on the completing cycle of a slot access
//   slv_dout      packed slave read data, slot0 in lsbs
//   led           internal LED register
//   unmapped_cnt  saturating unmapped-access counter
// Build option: define SYS_BUS_UNMAPPED_CNT_EN to enable the unmapped-access
// counter; otherwise unmapped_cnt is tied to zero.
module sys_bus_fabric
    import sys_bus_pkg::*;
#(
    parameter int                      DW       = 16,
    parameter int                      AW       = 32,
    parameter int                      NSLV     = DEF_NSLV,
    parameter int                      SEL_LSB  = 16,
    parameter int                      SEL_W    = DEF_SEL_W,
    parameter logic [NSLV*SEL_W-1:0]   SLV_BASE = DEF_SLV_BASE,
    parameter logic [NSLV*SEL_W-1:0]   SLV_MASK = DEF_SLV_MASK,
    parameter logic [NSLV*WAIT_W-1:0]  SLV_WAIT = DEF_SLV_WAIT,
    parameter logic [SEL_W-1:0]        LED_SEL  = DEF_LED_SEL,
    parameter int                      LED_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [AW-1:0]      cpu_ab,
    input  logic [DW-1:0]      cpu_do,
    input  logic               cpu_we,
    output logic [DW-1:0]      cpu_di,
    output logic               cpu_rdy,
    output logic [NSLV-1:0]    slv_sel,
    output logic               slv_rd,
    output logic               slv_wr,
    input  logic [NSLV*DW-1:0] slv_dout,
    output logic [LED_W-1:0]   led,
    output logic [7:0]         unmapped_cnt
);

    logic [NSLV-1:0]   dec_sel;
    logic              dec_led;
    logic              dec_unmapped;
    logic [WAIT_W-1:0] dec_wait;

    sys_bus_decode #(
        .AW       (AW),
        .NSLV     (NSLV),
        .SEL_LSB  (SEL_LSB),
        .SEL_W    (SEL_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK),
        .SLV_WAIT (SLV_WAIT),
        .LED_SEL  (LED_SEL)
    ) u_decode (
        .cpu_ab     (cpu_ab),
        .slv_sel_o  (dec_sel),
        .led_hit_o  (dec_led),
        .unmapped_o (dec_unmapped),
        .wait_o     (dec_wait)
    );

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              complete;
    logic              slot_hit;

    assign slot_hit = |dec_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The first wait-state cycle is spent in IDLE (rdy dropped combinationally),
    // so WAIT is loaded with W-1 and completes when the count reaches zero.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cpu_rdy  = 1'b1;
        complete = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (slot_hit && (dec_wait != '0)) begin
                    cpu_rdy = 1'b0;
                    cnt_d   = dec_wait - 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    complete = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cpu_rdy = 1'b0;
                    cnt_d   = cnt_q - 1'b1;
                end else begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign slv_sel = dec_sel;
    assign slv_rd  = !cpu_we && complete && slot_hit;
    assign slv_wr  =  cpu_we && complete && slot_hit;

    // Read mux: one-hot AND-OR over the slots, LED zero-extended, zero if unmapped.
    logic [DW-1:0] rdata;
    logic [DW-1:0] cpu_di_q, cpu_di_d;
    logic [LED_W-1:0] led_q, led_d;

    always_comb begin
        rdata = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (dec_sel[k]) rdata = rdata | slv_dout[k*DW +: DW];
        end
        if (dec_led) begin
            rdata              = '0;
            rdata[LED_W-1:0]   = led_q;
        end
    end

    // Reads refresh the data register every cycle so it holds the completing
    // cycle's value one cycle later; writes leave it alone.
    assign cpu_di_d = cpu_we ? cpu_di_q : rdata;
    assign led_d    = (complete && cpu_we && dec_led) ? cpu_do[LED_W-1:0] : led_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_di_q <= '0;
            led_q    <= '0;
        end else begin
            cpu_di_q <= cpu_di_d;
            led_q    <= led_d;
        end
    end

    assign cpu_di = cpu_di_q;
    assign led    = led_q;

    logic unused_do;
    assign unused_do = ^cpu_do;

`ifdef SYS_BUS_UNMAPPED_CNT_EN
    logic [7:0] ucnt_q, ucnt_d;

    assign ucnt_d = (complete && dec_unmapped && (ucnt_q != 8'hff)) ? ucnt_q + 8'd1 : ucnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ucnt_q <= 8'h00;
        else       ucnt_q <= ucnt_d;
    end

    assign unmapped_cnt = ucnt_q;
`else
    logic unused_unmapped;
    assign unused_unmapped = dec_unmapped;
    assign unmapped_cnt    = 8'h00;
`endif

endmodule

// File: tb/tb_sys_bus_fabric.sv
// Bench for sys_bus_fabric. The decode map is overridden so that the decode
// field is the top address byte: slot0=0x10, slot1=0xff (W=2), slot2=0xfe (W=1),
// slot3=0x00 (W=0), LED=0xfd, everything else unmapped.
module tb_sys_bus_fabric;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_ab;
    logic [15:0] cpu_do;
    logic        cpu_we;
    logic [15:0] cpu_di;
    logic        cpu_rdy;
    logic [3:0]  slv_sel;
    logic        slv_rd;
    logic        slv_wr;
    logic [63:0] slv_dout;
    logic [7:0]  led;
    logic [7:0]  unmapped_cnt;

    int checks = 0;
    int errors = 0;
    int nunm   = 0;

`ifdef SYS_BUS_UNMAPPED_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [31:0] PARK = 32'hfd00_0000;   // LED read: no strobes, not counted

    sys_bus_fabric #(
        .SEL_LSB  (24),
        .SLV_BASE ({8'h00, 8'hfe, 8'hff, 8'h10}),
        .SLV_MASK (32'hffff_ffff),
        .SLV_WAIT ({2'd0, 2'd1, 2'd2, 2'd0})
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_ab       (cpu_ab),
        .cpu_do       (cpu_do),
        .cpu_we       (cpu_we),
        .cpu_di       (cpu_di),
        .cpu_rdy      (cpu_rdy),
        .slv_sel      (slv_sel),
        .slv_rd       (slv_rd),
        .slv_wr       (slv_wr),
        .slv_dout     (slv_dout),
        .led          (led),
        .unmapped_cnt (unmapped_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_cnt(input int n);
        if (!CNT_EN) return 8'h00;
        return (n > 255) ? 8'hff : n[7:0];
    endfunction

    // One access, possibly waited. Called at posedge+1, returns at posedge+1
    // after the completing edge with cpu_di already updated.
    task automatic access(input string name, input logic [31:0] ab, input logic we,
                          input logic [15:0] d, input int exp_lows, input int exp_rd,
                          input int exp_wr, input logic [15:0] exp_di);
        int  lows = 0, rds = 0, wrs = 0;
        bit  done = 0;
        cpu_ab = ab; cpu_we = we; cpu_do = d;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk);
            if (!cpu_rdy) lows++;
            rds += int'(slv_rd);
            wrs += int'(slv_wr);
            if (cpu_rdy) done = 1;
            @(posedge clk); #1;
        end
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_lows"}, lows, exp_lows);
        chk({name, "_rd"},   rds,  exp_rd);
        chk({name, "_wr"},   wrs,  exp_wr);
        chk({name, "_di"},   cpu_di, exp_di);
        cpu_ab = PARK; cpu_we = 1'b0;
    endtask

    typedef struct {
        logic [31:0] ab;
        logic        we;
        logic [15:0] d;
        logic [3:0]  sel;
        logic        rd;
        logic        wr;
        logic [15:0] di;
        logic [7:0]  led;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{32'h0000_0010, 1'b0, 16'h0000, 4'b1000, 1'b1, 1'b0, 16'h1234, 8'h00};
        vecs[1] = '{32'h1000_0000, 1'b0, 16'h0000, 4'b0001, 1'b1, 1'b0, 16'h0a0a, 8'h00};
        vecs[2] = '{32'h0000_0020, 1'b1, 16'h5555, 4'b1000, 1'b0, 1'b1, 16'h0a0a, 8'h00};
        vecs[3] = '{32'hfd00_0000, 1'b1, 16'h00a5, 4'b0000, 1'b0, 1'b0, 16'h0a0a, 8'ha5};
        vecs[4] = '{32'hfd00_0000, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 16'h00a5, 8'ha5};
        vecs[5] = '{32'hfd00_0004, 1'b1, 16'h1234, 4'b0000, 1'b0, 1'b0, 16'h00a5, 8'h34};
        vecs[6] = '{32'hfd00_0000, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 16'h0034, 8'h34};
        vecs[7] = '{32'h8000_0000, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 16'h0000, 8'h34};
        vecs[8] = '{32'h80ff_0000, 1'b1, 16'hffff, 4'b0000, 1'b0, 1'b0, 16'h0000, 8'h34};
        vecs[9] = '{32'h8123_4567, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 16'h0000, 8'h34};

        slv_dout = {16'h1234, 16'h2222, 16'h1111, 16'h0a0a};
        cpu_ab = PARK; cpu_we = 1'b0; cpu_do = 16'h0000;
        reset = 1'b1;
        #12;
        chk("rst_rdy",  32'(cpu_rdy), 32'd1);
        chk("rst_di",   32'(cpu_di), 32'h0);
        chk("rst_led",  32'(led), 32'h0);
        chk("rst_cnt",  32'(unmapped_cnt), 32'h0);
        chk("rst_sel",  32'(slv_sel), 32'h0);
        @(negedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;

        // Single-cycle accesses: W=0 slots, LED, unmapped.
        foreach (vecs[i]) begin
            cpu_ab = vecs[i].ab; cpu_we = vecs[i].we; cpu_do = vecs[i].d;
            if (vecs[i].ab[31:24] != 8'hfd && vecs[i].sel == 4'b0000) nunm++;
            @(negedge clk);
            chk($sformatf("v%0d_rdy", i), 32'(cpu_rdy), 32'd1);
            chk($sformatf("v%0d_sel", i), 32'(slv_sel), 32'(vecs[i].sel));
            chk($sformatf("v%0d_rd",  i), 32'(slv_rd),  32'(vecs[i].rd));
            chk($sformatf("v%0d_wr",  i), 32'(slv_wr),  32'(vecs[i].wr));
            @(posedge clk); #1;
            chk($sformatf("v%0d_di",  i), 32'(cpu_di), 32'(vecs[i].di));
            chk($sformatf("v%0d_led", i), 32'(led),    32'(vecs[i].led));
        end
        cpu_ab = PARK; cpu_we = 1'b0;
        chk("unm_cnt3", 32'(unmapped_cnt), 32'(exp_cnt(nunm)));

        // Saturation: hold an unmapped address for 300 cycles.
        cpu_ab = 32'h8000_0000;
        repeat (300) begin
            @(posedge clk); #1;
            nunm++;
        end
        cpu_ab = PARK;
        chk("unm_sat", 32'(unmapped_cnt), 32'(exp_cnt(nunm)));

        // Waited accesses, including back-to-back on the W=2 slot.
        access("s2_rd",   32'hfe00_0001, 1'b0, 16'h0000, 1, 1, 0, 16'h2222);
        access("s1_wr",   32'hff00_0000, 1'b1, 16'hbeef, 2, 0, 1, 16'h2222);
        access("s1_rd",   32'hff00_0002, 1'b0, 16'h0000, 2, 1, 0, 16'h1111);
        chk("led_keep", 32'(led), 32'h34);

        // Reset in the middle of a slot1 wait: access aborted, no strobe.
        cpu_ab = 32'hff00_0000; cpu_we = 1'b0;
        @(negedge clk);
        chk("ab1_rdy0", 32'(cpu_rdy), 32'd0);
        chk("ab1_rd0",  32'(slv_rd), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ab2_rdy0", 32'(cpu_rdy), 32'd0);
        chk("ab2_rd0",  32'(slv_rd), 32'd0);
        #1 reset = 1'b1; cpu_ab = PARK;
        #1;
        chk("ab_rdy",  32'(cpu_rdy), 32'd1);
        chk("ab_rd",   32'(slv_rd), 32'd0);
        chk("ab_led",  32'(led), 32'h0);
        chk("ab_di",   32'(cpu_di), 32'h0);
        chk("ab_cnt",  32'(unmapped_cnt), 32'h0);
        @(negedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rdy", 32'(cpu_rdy), 32'd1);
        @(posedge clk); #1;
        access("post_s2", 32'hfe00_0000, 1'b0, 16'h0000, 1, 1, 0, 16'h2222);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
